cmd_link_arbiter: RTL
=====================

// Module: cmd_link_arbiter
// PURPOSE
// - Shares the edge-strobed command byte decoder between two byte sources: A (host UART RX) and B (local script engine).
// - Grants one source for a complete command frame and forwards its bytes as a slow, glitch-free data/strobe pair.
// - The decoder updates on the strobe falling edge.
// - Round-robin between frames. Frame length comes from the opcode (first byte).
// - Aborts stalled frames and resets the decoder so it never hangs mid-command.
// PARAMETERS
// - SETUP    2     clocks oData is stable, strobe low, before strobe rises (>=1)
// - PULSE    4     clocks strobe high, then clocks strobe low after it (>=1)
// - TIMEOUT  1000  max clocks waiting for the next byte of an open frame (>=2)
// PORTS
// - iClk          in   1  system clock, all logic on rising edge
// - iRst          in   1  reset, asynchronous, active-high
// - iA_Data       in   8  source A byte
// - iA_Valid      in   1  source A byte valid
// - oA_Ready      out  1  source A byte accepted when iA_Valid&&oA_Ready
// - iB_Data       in   8  source B byte
// - iB_Valid      in   1  source B byte valid
// - oB_Ready      out  1  source B byte accepted when iB_Valid&&oB_Ready
// - oData         out  8  byte to decoder imData (registered)
// - oData_Strobe  out  1  to decoder imData_Ready (registered)
// - oDec_Rst      out  1  decoder reset pulse (registered)
// - oGrant        out  2  one-hot owner {B,A}, 00 = none
// - oBusy         out  1  frame in progress (state != IDLE)
// BEHAVIOUR
// - Reset values: oData=0, oData_Strobe=0, oDec_Rst=0, oGrant=00, oBusy=0.
//   Round-robin pointer = A. Reset is effective immediately at any point, including mid-strobe.
// - FSM states: IDLE, SETUP, HIGH, LOW, WAIT, ABORT.
// - oA_Ready/oB_Ready: combinational. Only the selected/granted source, only in IDLE or WAIT.
// - IDLE: if exactly one source is valid, select it. If both are valid, select the pointer side.
//   - Accept in that cycle; set oGrant; latch byte into oData; go to SETUP.
//   - Frame length from opcode: 8'd1 -> 5 bytes, 8'd2 -> 2 bytes, other -> 1 byte.
//   - Load bytes-remaining = length-1.
// - SETUP: SETUP clocks, strobe 0 -> HIGH.
// - HIGH: PULSE clocks, strobe 1 -> LOW.
// - LOW: PULSE clocks, strobe 0. Then:
//   - bytes-remaining==0 -> IDLE. oGrant=00. Pointer = the other source.
//   - bytes-remaining>0 -> WAIT.
// - WAIT: only the granted source is ready. The other is held off even if valid.
//   - On accept: latch oData, decrement remaining, go to SETUP.
// - Throughput: one byte per 1+SETUP+2*PULSE clocks. The accept cycle is counted.
//   First strobe rise is SETUP+1 clocks after accept.
// - oData changes only on the accept clock edge, never while the strobe is high.
// - Timeout (see CONFIGURATION): a WAIT cycle counter starts at 0 on entry to WAIT.
//   - Reaching TIMEOUT-1 with no accept -> ABORT.
// - ABORT: oDec_Rst=1 for exactly PULSE clocks, strobe 0.
//   Then IDLE, oGrant=00, pointer = the other source. The partial frame is discarded.
// - Counters are sized by $clog2 of their parameter. No wrap beyond their terminal count.
// - A valid source is never dropped: the loser of an IDLE tie keeps its Valid.
//   It is granted next frame (round-robin guarantees this).
// CONFIGURATION
// - ARB_TIMEOUT_EN defined: WAIT timeout and ABORT state as above.
// - ARB_TIMEOUT_EN undefined: WAIT holds indefinitely. ABORT is unreachable. oDec_Rst is tied 0.
//   All other behaviour is identical.
// TESTING (SETUP=2, PULSE=4, TIMEOUT=1000)
// - Reset release, no valids -> all outputs 0. oA_Ready=oB_Ready=0 except in IDLE with valid.
// - A sends 01,11,22,33,44 back-to-back:
//   - oGrant=01 for the whole frame; exactly 5 strobe pulses, each 4 high / 4 low.
//   - Strobe rises 3 clocks after accept; oData steady while high.
//   - oBusy drops 11 clocks after the last accept.
// - A and B both valid in IDLE with opcode 02, pointer=A:
//   - A frame (2 strobes) completes with oB_Ready=0 throughout.
//   - Then B is granted next (oGrant=10).
// - B opcode 01 mid-frame while A is also valid:
//   - A stays blocked until B's 5th byte LOW completes.
// - Timeout enabled: A sends 01,AA then stalls:
//   - 1000 clocks into WAIT, oDec_Rst high 4 clocks.
//   - Then oGrant=00, and B is granted first if both are valid.
// - iRst asserted during HIGH -> strobe, grant and busy drop asynchronously.
//   After release, the next opcode from A starts a fresh frame.

Source files
------------

// File: rtl/cmd_link_arbiter_if.sv
// cmd_link_arbiter_if: byte-source handshakes and decoder-side outputs of the
// command link arbiter. The arbiter takes the slave view; sources, decoder and
// benches take the master view.
interface cmd_link_arbiter_if;
  logic [7:0] iA_Data;
  logic       iA_Valid;
  logic       oA_Ready;
  logic [7:0] iB_Data;
  logic       iB_Valid;
  logic       oB_Ready;
  logic [7:0] oData;
  logic       oData_Strobe;
  logic       oDec_Rst;
  logic [1:0] oGrant;
  logic       oBusy;

  modport slave (
    input  iA_Data, iA_Valid, iB_Data, iB_Valid,
    output oA_Ready, oB_Ready, oData, oData_Strobe, oDec_Rst, oGrant, oBusy
  );

  modport master (
    output iA_Data, iA_Valid, iB_Data, iB_Valid,
    input  oA_Ready, oB_Ready, oData, oData_Strobe, oDec_Rst, oGrant, oBusy
  );
endinterface

// File: rtl/cmd_link_arbiter.sv
// cmd_link_arbiter: shares one edge-strobed command decoder between source A
// (host UART RX) and source B (local script engine). One source owns the link
// for a whole command frame; frames alternate round-robin.
// Build option: define ARB_TIMEOUT_EN to abort frames stalled in WAIT and
// pulse the decoder reset. Without it WAIT holds forever and oDec_Rst is 0.
//
// state | meaning
// IDLE  | no frame open; select a source and accept its opcode
// SETUP | byte on oData, strobe low, waiting before the rising edge
// HIGH  | strobe high
// LOW   | strobe low after the pulse; decoder latched on the falling edge
// WAIT  | frame open, only the owner may deliver the next byte
// ABORT | stalled frame dropped, decoder held in reset
module cmd_link_arbiter #(
  parameter int SETUP   = 2,
  parameter int PULSE   = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic              iClk,
  input  logic              iRst,
  cmd_link_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_WAIT, S_ABORT
  } state_t;

  // One phase timer serves SETUP, HIGH, LOW and ABORT, so it is sized for
  // the larger of the two phase lengths.
  localparam int PH_MAX = (SETUP > PULSE) ? SETUP : PULSE;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int WC_W   = $clog2(TIMEOUT);

  localparam logic [PH_W-1:0] PH_SETUP = PH_W'(SETUP - 1);
  localparam logic [PH_W-1:0] PH_PULSE = PH_W'(PULSE - 1);
  localparam logic [WC_W-1:0] WC_TC    = WC_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [2:0]      rem_q, rem_d;
  logic [1:0]      grant_q, grant_d;
  logic            ptr_q, ptr_d;          // 0 = A next on a tie, 1 = B
  logic [7:0]      data_q, data_d;
  logic            strobe_q, strobe_d;

  logic            sel_b;
  logic            rdy_a, rdy_b;
  logic            acc_a, acc_b, acc;
  logic [7:0]      acc_byte;

  // Bytes still to come after the opcode.
  function automatic logic [2:0] frame_rem(input logic [7:0] op);
    case (op)
      8'd1:    frame_rem = 3'd4;
      8'd2:    frame_rem = 3'd1;
      default: frame_rem = 3'd0;
    endcase
  endfunction

  assign sel_b    = bus.iB_Valid && (!bus.iA_Valid || ptr_q);
  assign acc_a    = rdy_a && bus.iA_Valid;
  assign acc_b    = rdy_b && bus.iB_Valid;
  assign acc      = acc_a || acc_b;
  assign acc_byte = acc_b ? bus.iB_Data : bus.iA_Data;

  // Ready goes only to the selected source in IDLE or to the owner in WAIT.
  always_comb begin
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    case (state_q)
      S_IDLE: begin
        rdy_a = bus.iA_Valid && !sel_b;
        rdy_b = sel_b;
      end
      S_WAIT: begin
        rdy_a = grant_q[0];
        rdy_b = grant_q[1];
      end
      default: begin
        rdy_a = 1'b0;
        rdy_b = 1'b0;
      end
    endcase
  end

  // Next-state, phase timing and frame bookkeeping.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    wcnt_d  = wcnt_q;
    rem_d   = rem_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          grant_d = acc_b ? 2'b10 : 2'b01;
          data_d  = acc_byte;
          rem_d   = frame_rem(acc_byte);
          ph_d    = PH_SETUP;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (ph_q == '0) begin
          ph_d    = PH_PULSE;
          state_d = S_HIGH;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      S_HIGH: begin
        if (ph_q == '0) begin
          ph_d    = PH_PULSE;
          state_d = S_LOW;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      S_LOW: begin
        if (ph_q != '0) begin
          ph_d = ph_q - PH_W'(1);
        end else if (rem_q == 3'd0) begin
          grant_d = 2'b00;
          ptr_d   = grant_q[0];
          state_d = S_IDLE;
        end else begin
          wcnt_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (acc) begin
          data_d  = acc_byte;
          rem_d   = rem_q - 3'd1;
          ph_d    = PH_SETUP;
          state_d = S_SETUP;
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (wcnt_q == WC_TC) begin
            ph_d    = PH_PULSE;
            state_d = S_ABORT;
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
`else
          // Stall counter saturates; nothing acts on it in this build.
          if (wcnt_q != WC_TC) begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
`endif
        end
      end
      S_ABORT: begin
`ifdef ARB_TIMEOUT_EN
        if (ph_q == '0) begin
          grant_d = 2'b00;
          ptr_d   = grant_q[0];
          state_d = S_IDLE;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    strobe_d = (state_d == S_HIGH);
  end

  // State and registered outputs; reset acts at once, even mid-strobe.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      ph_q     <= '0;
      wcnt_q   <= '0;
      rem_q    <= 3'd0;
      grant_q  <= 2'b00;
      ptr_q    <= 1'b0;
      data_q   <= 8'd0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      wcnt_q   <= wcnt_d;
      rem_q    <= rem_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic dec_rst_q;

  // Decoder reset follows the ABORT state, registered for a clean pulse.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      dec_rst_q <= 1'b0;
    end else begin
      dec_rst_q <= (state_d == S_ABORT);
    end
  end

  assign bus.oDec_Rst = dec_rst_q;
`else
  assign bus.oDec_Rst = 1'b0;
`endif

  assign bus.oA_Ready     = rdy_a;
  assign bus.oB_Ready     = rdy_b;
  assign bus.oData        = data_q;
  assign bus.oData_Strobe = strobe_q;
  assign bus.oGrant       = grant_q;
  assign bus.oBusy        = (state_q != S_IDLE);

endmodule
